// File: rtl/bcd_pkg.sv
// Shared BCD types, digit limits and the digit validity check.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  function automatic logic is_valid_bcd(input bcd_digit_t digit);
    return (digit <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the ripple chain: next value and carry/borrow out.
module bcd_digit
  import bcd_pkg::*;
(
  input  bcd_digit_t cur,
  input  logic       up,
  input  logic       cin,
  output bcd_digit_t nxt,
  output logic       cout
);

  // Step only when a carry/borrow arrives; 9->0 going up, 0->9 going down.
  // A digit above 9 cannot be held, but it is treated like 9 so the chain
  // would still recover to a legal value.
  always_comb begin
    nxt  = cur;
    cout = 1'b0;
    if (cin) begin
      if (up) begin
        if (cur >= BCD_MAX) begin
          nxt  = BCD_MIN;
          cout = 1'b1;
        end else begin
          nxt = cur + 4'd1;
        end
      end else begin
        if (cur == BCD_MIN) begin
          nxt  = BCD_MAX;
          cout = 1'b1;
        end else begin
          nxt = cur - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_counter.sv
// N-digit BCD up/down counter with validated parallel load, wrap or
// saturate at the terminal count, and registered tc / load_err pulses.
module bcd_counter
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 3,
  parameter bit SATURATE   = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    up,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [4*NUM_DIGITS-1:0] q,
  output logic                    tc,
  output logic                    load_err
);

  localparam int W = 4 * NUM_DIGITS;

  logic [W-1:0]          q_q, q_d;
  logic [W-1:0]          step_val;
  logic                  tc_q, tc_d;
  logic                  err_q, err_d;
  logic [NUM_DIGITS:0]   carry;
  logic                  load_ok;

  // The carry out of the top digit is set exactly when an enabled step
  // starts from all-9s (up) or all-0s (down), i.e. the terminal count.
  assign carry[0] = en;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .cur  (q_q[4*g +: 4]),
      .up   (up),
      .cin  (carry[g]),
      .nxt  (step_val[4*g +: 4]),
      .cout (carry[g+1])
    );
  end

  // Accept a load only if every digit is a legal BCD digit.
  always_comb begin
    load_ok = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (!is_valid_bcd(load_val[4*k +: 4])) load_ok = 1'b0;
    end
  end

  // Next state: load beats count; both pulses default low every cycle.
  always_comb begin
    q_d   = q_q;
    tc_d  = 1'b0;
    err_d = 1'b0;
    if (load) begin
      if (load_ok) q_d   = load_val;
      else         err_d = 1'b1;
    end else if (en) begin
      tc_d = carry[NUM_DIGITS];
      if (SATURATE && carry[NUM_DIGITS]) q_d = q_q;
      else                               q_d = step_val;
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q   <= '0;
      tc_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      tc_q  <= tc_d;
      err_q <= err_d;
    end
  end

  assign q        = q_q;
  assign tc       = tc_q;
  assign load_err = err_q;

endmodule

// File: doc/bcd_counter.md
Name: bcd_counter

Overview:
Parametrised, clocked N-digit BCD up/down counter. It is the sequential successor to the combinational 3-digit BCD incrementor. It adds a configurable digit count, up/down mode, parallel load with digit validation, wrap or saturate at the terminal count, and a registered terminal-count pulse. It feeds the seven-segment display multiplexer and event-counting datapaths.

Parameters:
- NUM_DIGITS, 3: number of BCD digits. Legal range 1..8.
- SATURATE, 0: 0 = wrap at terminal count; 1 = hold at terminal count.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  count enable; one step per cycle while high.
- up  input  1  direction: 1 = increment, 0 = decrement. Sampled with en.
- load  input  1  parallel-load request.
- load_val  input  4*NUM_DIGITS  value to load; digit k occupies bits [4k+3:4k].
- q  output  4*NUM_DIGITS  current count; digit0 is the least significant digit.
- tc  output  1  one-cycle pulse when a step crosses or hits the terminal count.
- load_err  output  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset: synchronous, active-high. At the edge where reset=1: q=0, tc=0, load_err=0.
- Priority per edge: reset > load > en > hold.
- All outputs are registered. A step or load is visible on q one cycle after it is sampled.
- Load, valid case: every digit of load_val is ≤ 9.
  - q <= load_val, tc <= 0, load_err <= 0.
  - en is ignored in that cycle.
- Load, invalid case: any digit of load_val is > 9.
  - q holds, load_err <= 1 for one cycle, tc <= 0.
  - en is also ignored in that cycle.
- Increment (en=1, up=1):
  - digit0 +1. A digit at 9 becomes 0 and carries into the next digit; otherwise the digit +1 and the carry stops.
  - At all-9s (10^N − 1):
    - SATURATE=0: q <= 0, tc <= 1.
    - SATURATE=1: q holds all-9s, tc <= 1, and tc repeats each enabled cycle while held.
- Decrement (en=1, up=0):
  - A digit at 0 becomes 9 and borrows from the next digit; otherwise the digit −1.
  - At all-0s:
    - SATURATE=0: q <= all-9s, tc <= 1.
    - SATURATE=1: q holds 0, tc <= 1.
- tc is 0 on every other cycle, including en=0 cycles. tc is asserted in the same cycle that q shows the wrapped or held value.
- Direction changes take effect on the next enabled edge. There is no pipeline, so no stale steps occur.
- Reset asserted mid-count or coincident with load or en: reset wins and no tc or load_err pulse is produced.
- Arithmetic is strictly per-digit. q never contains a digit > 9 under any input sequence.

Decomposition:
- Package bcd_pkg:
  - typedef bcd_digit_t (logic [3:0]).
  - constants BCD_MAX = 4'd9 and BCD_MIN = 4'd0.
  - function is_valid_bcd(digit).
- Sub-module bcd_digit, instantiated NUM_DIGITS times via generate:
  - Combinational next-digit logic.
  - Inputs: cur, up, cin (carry/borrow in).
  - Outputs: nxt, cout.
  - cout=1 when cur=9 and up, or cur=0 and down, with cin=1.
  - The chain is rippled from digit0. cin of digit0 = en.
  - The top level holds the registers, the load/validation muxing, terminal-count detection and saturation.

Test Plan (NUM_DIGITS=3 unless noted):
- Reset: hold reset=1 with en=1 and load=1 for 2 cycles -> q=12'h000, tc=0, load_err=0. After release, en=1 for 5 cycles -> q=12'h005.
- Carry ripple and wrap, SATURATE=0: load 12'h099, en=1, up=1 -> q=12'h100 next cycle. Load 12'h999, step -> q=12'h000 with tc=1 for exactly one cycle.
- Borrow and down-wrap: load 12'h100, up=0 step -> q=12'h099. Load 12'h000, step -> q=12'h999, tc=1.
- Saturation, SATURATE=1: load 12'h998, up=1, en=1 for 4 cycles -> q=12'h999, 12'h999, 12'h999, 12'h999, with tc=0,1,1,1. Down from 12'h001 -> q=12'h000, then held.
- Load validation: load_val=12'h1A3 with en=1 -> q unchanged, load_err=1 for one cycle, no step. load_val=12'h123 -> q=12'h123.
- Exhaustive sweep: NUM_DIGITS=2, count up 100 steps from 0. Every q matches a scoreboard, and tc fires only on the 99→00 step. Then count down 100 steps back to 0.
